// File: rtl/debug_unit.sv
// Serial-link debug controller: loads instruction memory, runs/steps the pipeline, and dumps
// PC, registers and data memory. Define DEBUG_CYCLE_COUNT_EN to append an enable-cycle count.
module debug_unit #(
   parameter int unsigned        INST_SZ    = 32,
   parameter int unsigned        PC_SZ      = 32,
   parameter int unsigned        REG_SZ     = 5,
   parameter int unsigned        BYTE_SZ    = 8,
   parameter logic [INST_SZ-1:0] HALT_INSTR = 32'hFFFFFFFF
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic [BYTE_SZ-1:0] i_rx_data,
   input  logic               i_rx_done,
   input  logic               i_tx_done,
   output logic [BYTE_SZ-1:0] o_tx_data,
   output logic               o_tx_start,
   input  logic [PC_SZ-1:0]   i_pc,
   input  logic [INST_SZ-1:0] i_reg,
   input  logic [INST_SZ-1:0] i_mem,
   input  logic               i_halt,
   output logic [INST_SZ-1:0] o_instruction,
   output logic               o_write,
   output logic               o_enable,
   output logic [REG_SZ-1:0]  o_debug_addr,
   output logic               o_pipe_reset,
   output logic               o_busy
);

   typedef enum logic [2:0] {
      StIdle, StLoad, StRun, StStep, StDumpSet, StDumpLatch, StDumpSend, StDumpWait
   } state_t;

   localparam logic [BYTE_SZ-1:0] CmdLoad = BYTE_SZ'(8'h4C);
   localparam logic [BYTE_SZ-1:0] CmdRun  = BYTE_SZ'(8'h43);
   localparam logic [BYTE_SZ-1:0] CmdStep = BYTE_SZ'(8'h53);

   localparam logic [1:0] SecPc  = 2'd0;
   localparam logic [1:0] SecReg = 2'd1;
   localparam logic [1:0] SecMem = 2'd2;
`ifdef DEBUG_CYCLE_COUNT_EN
   localparam logic [1:0] SecCyc  = 2'd3;
   localparam logic [1:0] SecLast = SecCyc;
`else
   localparam logic [1:0] SecLast = SecMem;
`endif

   state_t             state_q;
   logic [1:0]         byte_cnt_q;
   logic [1:0]         sec_q;
   logic               settle_q;
   logic [INST_SZ-1:0] shift_q;
   logic [INST_SZ-1:0] dump_src;

   assign o_enable = ((state_q == StRun) & ~i_halt) | (state_q == StStep);
   assign o_busy   = (state_q != StIdle);

`ifdef DEBUG_CYCLE_COUNT_EN
   logic [31:0] cyc_q;

   always_ff @(posedge i_clk) begin
      if (i_reset || o_pipe_reset) begin
         cyc_q <= '0;
      end else if (o_enable && !(&cyc_q)) begin
         cyc_q <= cyc_q + 32'd1;
      end
   end
`endif

   always_comb begin
      dump_src = i_mem;
      case (sec_q)
         SecPc:   dump_src = INST_SZ'(i_pc);
         SecReg:  dump_src = i_reg;
`ifdef DEBUG_CYCLE_COUNT_EN
         SecCyc:  dump_src = INST_SZ'(cyc_q);
`endif
         default: dump_src = i_mem;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q       <= StIdle;
         byte_cnt_q    <= '0;
         sec_q         <= SecPc;
         settle_q      <= 1'b0;
         shift_q       <= '0;
         o_tx_data     <= '0;
         o_tx_start    <= 1'b0;
         o_instruction <= '0;
         o_write       <= 1'b0;
         o_debug_addr  <= '0;
         o_pipe_reset  <= 1'b0;
      end else begin
         o_write      <= 1'b0;
         o_pipe_reset <= 1'b0;
         o_tx_start   <= 1'b0;
         unique case (state_q)
            StIdle: begin
               byte_cnt_q   <= '0;
               sec_q        <= SecPc;
               settle_q     <= 1'b0;
               o_debug_addr <= '0;
               if (i_rx_done) begin
                  case (i_rx_data)
                     CmdLoad: begin
                        state_q      <= StLoad;
                        o_pipe_reset <= 1'b1;
                     end
                     // A halted pipeline must not see an enable cycle, so skip straight to the dump.
                     CmdRun:  state_q <= i_halt ? StDumpSet : StRun;
                     CmdStep: state_q <= i_halt ? StDumpSet : StStep;
                     default: state_q <= StIdle;
                  endcase
               end
            end
            StLoad: begin
               if (o_write && (o_instruction == HALT_INSTR)) begin
                  state_q <= StIdle;
               end else if (i_rx_done) begin
                  o_instruction <= {o_instruction[INST_SZ-BYTE_SZ-1:0], i_rx_data};
                  byte_cnt_q    <= byte_cnt_q + 2'd1;
                  if (byte_cnt_q == 2'd3) o_write <= 1'b1;
               end
            end
            StRun: begin
               if (i_halt) state_q <= StDumpSet;
            end
            StStep: state_q <= StDumpSet;
            StDumpSet: begin
               settle_q <= 1'b0;
               state_q  <= StDumpLatch;
            end
            StDumpLatch: begin
               if (!settle_q) begin
                  settle_q <= 1'b1;
               end else begin
                  settle_q <= 1'b0;
                  shift_q  <= dump_src;
                  state_q  <= StDumpSend;
               end
            end
            StDumpSend: begin
               o_tx_start <= 1'b1;
               o_tx_data  <= shift_q[INST_SZ-1 -: BYTE_SZ];
               state_q    <= StDumpWait;
            end
            StDumpWait: begin
               if (i_tx_done) begin
                  shift_q    <= shift_q << BYTE_SZ;
                  byte_cnt_q <= byte_cnt_q + 2'd1;
                  if (byte_cnt_q != 2'd3) begin
                     state_q <= StDumpSend;
                  end else if (sec_q == SecPc) begin
                     sec_q   <= SecReg;
                     state_q <= StDumpSet;
                  end else if ((sec_q == SecReg) || (sec_q == SecMem)) begin
                     // Address wrap ends the section and leaves o_debug_addr back at 0.
                     o_debug_addr <= o_debug_addr + 1'b1;
                     if (&o_debug_addr) begin
                        if (sec_q == SecLast) begin
                           state_q <= StIdle;
                        end else begin
                           sec_q   <= sec_q + 2'd1;
                           state_q <= StDumpSet;
                        end
                     end else begin
                        state_q <= StDumpSet;
                     end
                  end else begin
                     state_q <= StIdle;
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_debug_unit.sv
// Randomized bench for debug_unit: directed command sequence, random data and TX latency,
// dumps checked against a reference byte stream built from the PC/register/memory models.
module tb_debug_unit;

`ifdef DEBUG_CYCLE_COUNT_EN
   localparam int DumpLen = 264;
`else
   localparam int DumpLen = 260;
`endif

   logic        i_clk = 1'b0;
   logic        i_reset;
   logic [7:0]  i_rx_data;
   logic        i_rx_done;
   logic        i_tx_done;
   logic [7:0]  o_tx_data;
   logic        o_tx_start;
   logic [31:0] i_pc;
   logic [31:0] i_reg;
   logic [31:0] i_mem;
   logic        i_halt;
   logic [31:0] o_instruction;
   logic        o_write;
   logic        o_enable;
   logic [4:0]  o_debug_addr;
   logic        o_pipe_reset;
   logic        o_busy;

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0]  tx_q[$];
   logic [7:0]  exp_q[$];
   logic [31:0] wr_q[$];
   logic [31:0] exp_wr_q[$];
   int          en_cnt = 0;
   int          prst_cnt = 0;
   int          bad_start = 0;
   logic [31:0] exp_cyc = 0;

   always #5 i_clk = ~i_clk;

   // Register file and data memory models.
   assign i_reg = {27'b0, o_debug_addr};
   assign i_mem = 32'(o_debug_addr) * 32'd4;

   debug_unit dut (
      .i_clk         (i_clk),
      .i_reset       (i_reset),
      .i_rx_data     (i_rx_data),
      .i_rx_done     (i_rx_done),
      .i_tx_done     (i_tx_done),
      .o_tx_data     (o_tx_data),
      .o_tx_start    (o_tx_start),
      .i_pc          (i_pc),
      .i_reg         (i_reg),
      .i_mem         (i_mem),
      .i_halt        (i_halt),
      .o_instruction (o_instruction),
      .o_write       (o_write),
      .o_enable      (o_enable),
      .o_debug_addr  (o_debug_addr),
      .o_pipe_reset  (o_pipe_reset),
      .o_busy        (o_busy)
   );

   always @(negedge i_clk) begin
      if (o_write) wr_q.push_back(o_instruction);
      if (o_enable) en_cnt++;
      if (o_pipe_reset) prst_cnt++;
   end

   // UART TX model: accepts a byte, finishes it after a random latency.
   initial begin
      int d;
      i_tx_done = 1'b0;
      forever begin
         @(negedge i_clk);
         if (o_tx_start) begin
            tx_q.push_back(o_tx_data);
            d = $urandom_range(0, 3);
            for (int k = 0; k < d; k++) begin
               @(negedge i_clk);
               if (o_tx_start) bad_start++;
            end
            i_tx_done = 1'b1;
            @(negedge i_clk);
            if (o_tx_start) bad_start++;
            i_tx_done = 1'b0;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(negedge i_clk);
      i_rx_data = b;
      i_rx_done = 1'b1;
      @(negedge i_clk);
      i_rx_done = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int b = 3; b >= 0; b--) send_byte(w[8*b +: 8]);
   endtask

   task automatic wait_idle(input string tag);
      int k;
      for (k = 0; k < 20000; k++) begin
         @(negedge i_clk);
         if (!o_busy) break;
      end
      chk(tag, 32'(k < 20000), 32'd1);
   endtask

   function automatic void push_word(input logic [31:0] w);
      for (int b = 3; b >= 0; b--) exp_q.push_back(w[8*b +: 8]);
   endfunction

   // Reference stream: PC, then 32 register words, then 32 memory words (+ cycle count).
   function automatic void build_dump(input logic [31:0] pc);
      exp_q.delete();
      push_word(pc);
      for (int a = 0; a < 32; a++) push_word(32'(a));
      for (int a = 0; a < 32; a++) push_word(32'(a) * 32'd4);
      if (DumpLen == 264) push_word(exp_cyc);
   endfunction

   task automatic check_dump(input string tag);
      logic [7:0] obs;
      build_dump(i_pc);
      chk({tag, "_len"}, 32'(tx_q.size()), 32'(DumpLen));
      for (int i = 0; i < exp_q.size(); i++) begin
         obs = (i < tx_q.size()) ? tx_q[i] : 8'hxx;
         chk($sformatf("%s_byte%0d", tag, i), 32'(obs), 32'(exp_q[i]));
      end
      chk({tag, "_addr0"}, 32'(o_debug_addr), 32'd0);
      chk({tag, "_overlap"}, 32'(bad_start), 32'd0);
      tx_q.delete();
   endtask

   initial begin
      logic [31:0] w;
      int wr_before;
      int prst_before;

      i_reset   = 1'b1;
      i_rx_data = 8'h00;
      i_rx_done = 1'b0;
      i_halt    = 1'b0;
      i_pc      = $urandom;
      repeat (3) @(negedge i_clk);
      i_reset = 1'b0;
      @(negedge i_clk);
      chk("rst_tx_start", 32'(o_tx_start), 32'd0);
      chk("rst_tx_data", 32'(o_tx_data), 32'd0);
      chk("rst_write", 32'(o_write), 32'd0);
      chk("rst_instr", o_instruction, 32'd0);
      chk("rst_enable", 32'(o_enable), 32'd0);
      chk("rst_addr", 32'(o_debug_addr), 32'd0);
      chk("rst_pipe_reset", 32'(o_pipe_reset), 32'd0);
      chk("rst_busy", 32'(o_busy), 32'd0);

      // Load: the given word, a random word, then the terminator.
      send_byte(8'h4C);
      exp_wr_q.push_back(32'h20010005);
      w = $urandom;
      if (w == 32'hFFFFFFFF) w = 32'h0;
      exp_wr_q.push_back(w);
      exp_wr_q.push_back(32'hFFFFFFFF);
      foreach (exp_wr_q[i]) send_word(exp_wr_q[i]);
      exp_cyc = 0;
      repeat (2) @(negedge i_clk);
      chk("load_pipe_reset", 32'(prst_cnt), 32'd1);
      chk("load_nwrites", 32'(wr_q.size()), 32'(exp_wr_q.size()));
      foreach (exp_wr_q[i]) begin
         chk($sformatf("load_word%0d", i), (i < wr_q.size()) ? wr_q[i] : 32'hxxxxxxxx,
             exp_wr_q[i]);
      end
      chk("load_idle", 32'(o_busy), 32'd0);

      // Unknown command byte in idle is ignored.
      send_byte(8'h41);
      @(negedge i_clk);
      chk("ign_busy", 32'(o_busy), 32'd0);
      chk("ign_writes", 32'(wr_q.size()), 32'(exp_wr_q.size()));

      // Run: pipeline halts after 10 enable cycles.
      i_pc = $urandom;
      en_cnt = 0;
      send_byte(8'h43);
      repeat (10) @(posedge i_clk);
      #1 i_halt = 1'b1;
      #1 chk("run_en_on_halt", 32'(o_enable), 32'd0);
      exp_cyc = exp_cyc + 10;
      wait_idle("run_done");
      chk("run_en_cycles", 32'(en_cnt), 32'd10);
      check_dump("run");

      // Single step, with a stray 'L' arriving mid-dump.
      i_halt = 1'b0;
      i_pc = $urandom;
      en_cnt = 0;
      wr_before = wr_q.size();
      prst_before = prst_cnt;
      send_byte(8'h53);
      exp_cyc = exp_cyc + 1;
      repeat ($urandom_range(20, 200)) @(negedge i_clk);
      chk("step_busy_mid", 32'(o_busy), 32'd1);
      send_byte(8'h4C);
      wait_idle("step_done");
      chk("step_en_cycles", 32'(en_cnt), 32'd1);
      chk("step_no_write", 32'(wr_q.size()), 32'(wr_before));
      chk("step_no_prst", 32'(prst_cnt), 32'(prst_before));
      check_dump("step");

      // Step while already halted: no enable, dump still sent.
      i_halt = 1'b1;
      i_pc = $urandom;
      en_cnt = 0;
      send_byte(8'h53);
      wait_idle("hstep_done");
      chk("hstep_en_cycles", 32'(en_cnt), 32'd0);
      check_dump("hstep");

      // Reset in the middle of a load word.
      i_halt = 1'b0;
      wr_before = wr_q.size();
      send_byte(8'h4C);
      send_byte(8'h12);
      send_byte(8'h34);
      @(negedge i_clk);
      i_reset = 1'b1;
      @(negedge i_clk);
      i_reset = 1'b0;
      exp_cyc = 0;
      @(negedge i_clk);
      chk("mrst_busy", 32'(o_busy), 32'd0);
      chk("mrst_no_write", 32'(wr_q.size()), 32'(wr_before));
      i_pc = $urandom;
      en_cnt = 0;
      send_byte(8'h53);
      exp_cyc = exp_cyc + 1;
      chk("mrst_cmd_busy", 32'(o_busy), 32'd1);
      wait_idle("mrst_done");
      chk("mrst_en_cycles", 32'(en_cnt), 32'd1);
      chk("mrst_no_write2", 32'(wr_q.size()), 32'(wr_before));
      check_dump("mrst");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/debug_unit.md
Name: debug_unit

Overview:
- Host-side controller that drives the pipeline's debug/load interface from a byte-oriented serial link (UART RX/TX handshakes).
- Loads program words into instruction memory and issues run and single-step commands.
- After execution it sweeps the debug address and streams PC, the register file and data memory back to the host.
- Sits between the UART core and the pipeline top in the FPGA top level.

Parameters:
- INST_SZ, 32, instruction/data word width
- PC_SZ, 32, PC width
- REG_SZ, 5, debug address width (sweep covers 2^REG_SZ entries)
- BYTE_SZ, 8, serial byte width
- HALT_INSTR, 32'hFFFFFFFF, word that terminates a load stream

Ports:
- i_clk  in  1  clock
- i_reset  in  1  reset
- i_rx_data  in  BYTE_SZ  received byte
- i_rx_done  in  1  one-cycle pulse, i_rx_data valid
- i_tx_done  in  1  one-cycle pulse, TX finished current byte
- o_tx_data  out  BYTE_SZ  byte to send
- o_tx_start  out  1  one-cycle pulse, start TX of o_tx_data
- i_pc  in  PC_SZ  pipeline PC
- i_reg  in  INST_SZ  register file word at o_debug_addr
- i_mem  in  INST_SZ  data memory word at o_debug_addr
- i_halt  in  1  pipeline halted
- o_instruction  out  INST_SZ  word to write into instruction memory
- o_write  out  1  one-cycle instruction-memory write strobe
- o_enable  out  1  pipeline execution enable
- o_debug_addr  out  REG_SZ  debug read address
- o_pipe_reset  out  1  one-cycle pipeline reset pulse
- o_busy  out  1  high in any state except IDLE

Behaviour:
- Clock and reset: one clock, i_clk. i_reset is synchronous and active-high.
- Reset values: state IDLE; every output 0; o_debug_addr 0; byte and word counters 0.
- IDLE, command decode on an i_rx_done byte:
  - 0x4C 'L': go to LOAD and pulse o_pipe_reset for 1 cycle.
  - 0x43 'C': go to RUN.
  - 0x53 'S': go to STEP.
  - Any other byte is ignored and the unit stays in IDLE.
- LOAD:
  - Collects 4 bytes per word, MSB first, into o_instruction.
  - On the 4th byte, o_write pulses high in the next cycle with o_instruction stable.
  - If that word == HALT_INSTR, return to IDLE after the write; otherwise keep collecting.
  - A partial word persists indefinitely; there is no timeout.
- RUN:
  - o_enable = (state==RUN) & ~i_halt, combinational, so the pipeline never advances once halt is seen.
  - On i_halt=1, go to DUMP.
- STEP: o_enable high for exactly 1 cycle, then go to DUMP.
- Already halted: if i_halt=1 when 'C' or 'S' is accepted, o_enable stays 0 and the unit goes straight to DUMP.
- DUMP sequence:
  - Send i_pc (4 bytes, MSB first).
  - Then for addr = 0 .. 2^REG_SZ-1, send i_reg[addr] (4 bytes each).
  - Then for addr = 0 .. 2^REG_SZ-1, send i_mem[addr] (4 bytes each).
  - Default total: 4 + 128 + 128 = 260 bytes.
  - Per word: DUMP_SET drives o_debug_addr. DUMP_LATCH waits 1 settle cycle, then captures the source into a shift register. Each byte then goes through DUMP_SEND (pulse o_tx_start with o_tx_data = top byte) and DUMP_WAIT (wait for i_tx_done, then shift).
  - After the last byte, o_debug_addr returns to 0 and the state to IDLE.
- Input handling outside the expected states:
  - i_rx_done outside IDLE/LOAD is dropped.
  - i_tx_done outside DUMP_WAIT is ignored.
- Counter rules: the byte counter wraps 3→0. The address counter is REG_SZ bits, and its wrap marks the end of a section. The 2-bit section counter covers PC, REG and MEM.
- Reset mid-operation: any state returns to IDLE in the next cycle. A partially received word is discarded; no write, no TX pulse.

Optional Feature:
- Macro: DEBUG_CYCLE_COUNT_EN.
- When defined:
  - A 32-bit counter increments on every cycle with o_enable=1.
  - It clears on o_pipe_reset or i_reset and saturates at 32'hFFFFFFFF.
  - Its value is appended as 4 bytes, MSB first, after the memory section, making a 264-byte dump.
- When undefined: no counter is built and the dump is 260 bytes.

Test Plan:
- Load: reset, then bytes 4C, 20 01 00 05, FF FF FF FF → one o_pipe_reset pulse; o_write pulses twice, with o_instruction = 32'h20010005 then 32'hFFFFFFFF; back to IDLE with o_busy=0.
- Run to halt: after the load, send 'C'; model asserts i_halt 10 cycles later → o_enable high for exactly 10 cycles, 0 on the halt cycle; 260 o_tx_start pulses, each separated by i_tx_done; first 4 bytes equal i_pc MSB first.
- Sweep: reg model returns {27'b0, addr} and mem model returns addr*4 → register bytes 00 00 00 00, 00 00 00 01 … 00 00 00 1F; memory words 0, 4, …, 0x7C.
- Step: send 'S' with i_halt=0 → o_enable high for exactly 1 cycle, then a full dump; a second 'S' with i_halt=1 → o_enable never asserted, dump still sent.
- Ignored input: bytes 0x41 in IDLE and 0x4C mid-dump → no state change and no write; dump byte count is unaffected.
- Reset mid-load: send 4C, 12, 34, then i_reset → no o_write; a following 'S' is decoded as a command (not as load data).
